// File: rtl/hs_pkg.sv
// Shared types and parameter-legality helpers for the 4-phase to synchronous FIFO bridge.
package hs_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } hs_state_e;

  localparam int MIN_DEPTH = 2;
  localparam int MIN_SYNC  = 2;

  function automatic bit depth_ok(input int depth);
    return (depth >= MIN_DEPTH) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit sync_ok(input int stages);
    return stages >= MIN_SYNC;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop chain bringing an asynchronous level into the clk domain.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff_q <= {STAGES{RST_VAL}};
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/hs_to_sync.sv
// Captures 4-phase bundled-data handshakes into a first-word-fall-through FIFO.
// state | meaning
// IDLE  | a_i low, waiting for synchronized request with FIFO space
// ACK   | word captured, a_i high until the request drops
module hs_to_sync
  import hs_pkg::*;
#(
  parameter int N     = 1,
  parameter int DEPTH = 4,
  parameter int SYNC  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       r_i,
  output logic                       a_i,
  input  logic [N-1:0]               d_i,
  output logic                       valid_o,
  input  logic                       ready_o,
  output logic [N-1:0]               d_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("hs_to_sync: DEPTH must be a power of 2 and >= 2");
  end
  if (!sync_ok(SYNC)) begin : g_bad_sync
    $error("hs_to_sync: SYNC must be >= 2");
  end

  logic          r_s;
  hs_state_e     state_q;
  logic          a_q;
  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, push, pop;

  sync_ff #(
    .STAGES  (SYNC),
    .RST_VAL (1'b0)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (r_i),
    .q_o (r_s)
  );

  // Full is judged on the registered count, so a same-cycle pop cannot unblock a write.
  assign full = (count_q == CW'(DEPTH));
  assign push = (state_q == IDLE) && r_s && !full;
  assign pop  = (count_q != '0) && ready_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (push) begin
            state_q <= ACK;
            a_q     <= 1'b1;
          end
        end
        ACK: begin
          if (!r_s) begin
            state_q <= IDLE;
            a_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          a_q     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= d_i;
  end

  assign a_i     = a_q;
  assign valid_o = (count_q != '0);
  assign d_o     = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: tb/tb_hs_to_sync.sv
// Bench for hs_to_sync: table-driven handshakes, scoreboard on FIFO pops, corner sequences.
module tb_hs_to_sync;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int LAT   = SYNC + 1;

  typedef struct {
    logic [7:0] d;
    logic       ready;
    logic       exp_ack;
    int         exp_cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       r_i = 1'b0;
  logic       a_i;
  logic [7:0] d_i = '0;
  logic       valid_o;
  logic       ready_o = 1'b0;
  logic [7:0] d_o;
  logic [2:0] count_o;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  hs_to_sync #(.N(N), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
    .clk     (clk),
    .rst     (rst),
    .r_i     (r_i),
    .a_i     (a_i),
    .d_i     (d_i),
    .valid_o (valid_o),
    .ready_o (ready_o),
    .d_o     (d_o),
    .count_o (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A pop happens at the next edge when valid and ready are both high here.
  always @(negedge clk) begin
    if (!rst && valid_o && ready_o) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 1, 0);
      end else begin
        check("pop_data", int'(d_o), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_a(input logic lvl, input int bound, output int lat);
    lat = -1;
    for (int k = 1; k <= bound; k++) begin
      tick();
      if (a_i == lvl) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_hs(input vec_t v, input string tag);
    int lat;
    d_i = v.d;
    ready_o = v.ready;
    r_i = 1'b1;
    exp_q.push_back(v.d);
    wait_a(1'b1, LAT + 3, lat);
    check({tag, "_acked"}, int'(lat != -1), int'(v.exp_ack));
    if (lat != -1) begin
      check({tag, "_rise_lat"}, lat, LAT);
      check({tag, "_count"}, int'(count_o), v.exp_cnt);
      r_i = 1'b0;
      wait_a(1'b0, LAT + 3, lat);
      check({tag, "_fall_lat"}, lat, LAT);
    end else begin
      check({tag, "_count_full"}, int'(count_o), v.exp_cnt);
    end
  endtask

  task automatic drain();
    ready_o = 1'b1;
    for (int k = 0; k < 4 * DEPTH; k++) begin
      if (count_o == 0) break;
      tick();
    end
    ready_o = 1'b0;
    check("drain_count", int'(count_o), 0);
  endtask

  vec_t fill_tbl[5];
  vec_t wrap_tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    int lat;

    for (int i = 0; i < 5; i++)
      fill_tbl[i] = '{d: 8'(i + 1), ready: 1'b0, exp_ack: (i < DEPTH), exp_cnt: (i < DEPTH) ? i + 1 : DEPTH};
    for (int i = 0; i < 10; i++)
      wrap_tbl[i] = '{d: 8'(8'h10 + 8'(i * 7)), ready: 1'b1, exp_ack: 1'b1, exp_cnt: 1};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_a", int'(a_i), 0);
    check("rst_valid", int'(valid_o), 0);
    check("rst_count", int'(count_o), 0);
    rst = 1'b0;
    tick();

    // Single handshake with edge-by-edge latency
    d_i = 8'hA5;
    ready_o = 1'b0;
    r_i = 1'b1;
    exp_q.push_back(8'hA5);
    tick(); check("single_e1_a", int'(a_i), 0);
    tick(); check("single_e2_a", int'(a_i), 0);
    tick();
    check("single_e3_a", int'(a_i), 1);
    check("single_e3_valid", int'(valid_o), 1);
    check("single_e3_d", int'(d_o), 8'hA5);
    check("single_e3_count", int'(count_o), 1);
    r_i = 1'b0;
    tick(); check("single_f1_a", int'(a_i), 1);
    tick(); check("single_f2_a", int'(a_i), 1);
    tick(); check("single_f3_a", int'(a_i), 0);
    drain();

    // Fill past capacity; fifth request stalls
    for (int i = 0; i < 5; i++) do_hs(fill_tbl[i], $sformatf("fill%0d", i));
    check("fill_a_stalled", int'(a_i), 0);
    ready_o = 1'b1;
    tick();
    ready_o = 1'b0;
    check("fill_after_pop_count", int'(count_o), DEPTH - 1);
    check("fill_a_still_low", int'(a_i), 0);
    wait_a(1'b1, LAT + 3, lat);
    check("fill5_late_lat", lat, 1);
    check("fill5_count", int'(count_o), DEPTH);
    r_i = 1'b0;
    wait_a(1'b0, LAT + 3, lat);
    check("fill5_fall_lat", lat, LAT);
    drain();

    // Simultaneous push and pop at count 2
    do_hs('{d: 8'h21, ready: 1'b0, exp_ack: 1'b1, exp_cnt: 1}, "sim_a");
    do_hs('{d: 8'h22, ready: 1'b0, exp_ack: 1'b1, exp_cnt: 2}, "sim_b");
    d_i = 8'h33;
    r_i = 1'b1;
    exp_q.push_back(8'h33);
    tick();
    tick();
    ready_o = 1'b1;
    tick();
    ready_o = 1'b0;
    check("sim_a_up", int'(a_i), 1);
    check("sim_count", int'(count_o), 2);
    check("sim_head", int'(d_o), 8'h22);
    r_i = 1'b0;
    wait_a(1'b0, LAT + 3, lat);
    check("sim_fall_lat", lat, LAT);
    drain();

    // Streaming with ready high: pointers wrap twice
    for (int i = 0; i < 10; i++) do_hs(wrap_tbl[i], $sformatf("wrap%0d", i));
    tick();
    check("wrap_count_end", int'(count_o), 0);
    ready_o = 1'b0;

    // Reset while in ACK with request still high
    d_i = 8'h5A;
    r_i = 1'b1;
    exp_q.push_back(8'h5A);
    wait_a(1'b1, LAT + 3, lat);
    check("rstack_pre_lat", lat, LAT);
    rst = 1'b1;
    tick();
    check("rstack_a", int'(a_i), 0);
    check("rstack_count", int'(count_o), 0);
    check("rstack_valid", int'(valid_o), 0);
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h5A);
    tick(); check("rstack_e1_a", int'(a_i), 0);
    tick(); check("rstack_e2_a", int'(a_i), 0);
    tick();
    check("rstack_e3_a", int'(a_i), 1);
    check("rstack_e3_count", int'(count_o), 1);
    check("rstack_e3_d", int'(d_o), 8'h5A);
    r_i = 1'b0;
    wait_a(1'b0, LAT + 3, lat);
    check("rstack_fall_lat", lat, LAT);
    drain();

    // Ready while empty is ignored
    ready_o = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("empty_valid", int'(valid_o), 0);
      check("empty_count", int'(count_o), 0);
    end
    ready_o = 1'b0;
    tick();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hs_to_sync.md
HS_TO_SYNC -- requirements
Module: hs_to_sync

Interface
REQ-001 Parameters SHALL be (name, default, meaning): N, 1, data width; DEPTH, 4, FIFO entries, power of 2 and >=2; SYNC, 2, synchronizer stages, >=2.
REQ-002 clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high: rst=1 at a rising clk edge resets the block.
REQ-004 r_i  input  1  asynchronous 4-phase request from the upstream merge stage.
REQ-005 a_i  output  1  4-phase acknowledge to upstream; registered.
REQ-006 d_i  input  N  bundled data; stable from before r_i rises until a_i is seen high.
REQ-007 valid_o  output  1  FIFO head valid.
REQ-008 ready_o  input  1  downstream consumer accepts the head.
REQ-009 d_o  output  N  FIFO head data, first-word-fall-through.
REQ-010 count_o  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-011 r_i SHALL pass through a SYNC-stage flop chain; r_s is the last stage, and no other logic SHALL sample r_i.
REQ-012 The FSM SHALL have two states: IDLE (a_i=0) and ACK (a_i=1).
REQ-013 IDLE, r_s=1 and count_o<DEPTH at an edge: write d_i to mem[wr_ptr], increment wr_ptr, set a_i<=1, go to ACK.
REQ-014 IDLE, r_s=1 and count_o==DEPTH: no write, a_i stays 0, remain IDLE; a pop in the same cycle does not enable the write until the next cycle.
REQ-015 ACK, r_s=0: set a_i<=0, go to IDLE; ACK, r_s=1: hold.
REQ-016 Exactly one FIFO write SHALL occur per 4-phase handshake.
REQ-017 Latency: a_i and valid_o rise on the (SYNC+1)th rising edge after r_i rises, counting the first edge that samples it; a_i falls SYNC+1 edges after r_i falls.
REQ-018 A pop occurs when valid_o=1 and ready_o=1 at an edge; rd_ptr increments and count_o decrements.
REQ-019 valid_o SHALL equal (count_o!=0), and d_o SHALL equal mem[rd_ptr] combinationally.
REQ-020 A push and pop at the same edge SHALL leave count_o unchanged and move both pointers.
REQ-021 ready_o=1 while empty SHALL be ignored.
REQ-022 Pointers SHALL wrap modulo DEPTH.
REQ-023 count_o SHALL never exceed DEPTH or underflow.

Reset
REQ-024 On rst=1: a_i=0, state IDLE, pointers 0, count_o=0, valid_o=0, synchronizer flops 0; mem contents are don't-care.
REQ-025 Reset mid-handshake SHALL abort it; if r_i is still high after rst falls, it SHALL be treated as a new request after SYNC+1 edges. The upstream stage must be reset together with this block.
REQ-026 rst SHALL take priority over push and pop in the same cycle.

Structure
REQ-027 A shared package hs_pkg SHALL hold the FSM state typedef (IDLE, ACK) and the parameter-legality constants.
REQ-028 The synchronizer SHALL be the sub-module sync_ff, with parameters STAGES and reset value.
REQ-029 The FIFO SHALL be inline: register array plus pointers; no other sub-modules.
REQ-030 An illegal DEPTH or SYNC SHALL cause an elaboration error.

Verification (N=8, DEPTH=4, SYNC=2)
REQ-031 Single handshake: d_i=0xA5, r_i up, ready_o=0 -> a_i=1 and valid_o=1, d_o=0xA5, count_o=1 at edge 3; r_i down -> a_i=0 at edge 3 after the fall.
REQ-032 Fill: five handshakes 0x01..0x05, ready_o=0 -> count_o=4 and the 5th a_i stays 0; one pop -> 5th acked, d_o sequence 0x01..0x05 preserved.
REQ-033 Simultaneous: count_o=2, pop and capture on the same edge -> count_o stays 2, order preserved.
REQ-034 Wrap: 10 handshakes with ready_o=1 -> all values out in order, pointers wrap twice, count_o <=1.
REQ-035 Reset in ACK: rst pulsed with r_i=1 -> a_i=0, count_o=0 next edge; r_i held -> new capture 3 edges after rst falls.
REQ-036 Empty pop: ready_o=1, count_o=0 for 5 cycles -> valid_o=0, count_o=0.
